// File: rtl/mem_stage_ctrl.sv
// Memory stage: drives a stalling data memory from the EX/MEM latch
// and registers the MEM/WB result, with timeout and halt handling.
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_b,
  input  logic              ex_mem_en,
  input  logic              ex_mem_wr,
  input  logic              ex_mem2reg,
  input  logic              ex_regwrite,
  input  logic [2:0]        ex_wreg,
  input  logic              ex_dump,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_dump,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_out,
  output logic              wb_regwrite,
  output logic [2:0]        wb_wreg,
  output logic [DATA_W-1:0] wb_data,
  output logic              halt_out,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  logic op;
  logic issue;
  logic capture;
  logic timeout;
  logic pass;
  logic stall;
  logic dumpFire;

  // once halted, memory ops degrade to pass-through
  assign op = ex_valid & ex_mem_en
            & ~ex_dump & ~halt_out;

  assign dumpFire = (state == IDLE) & ex_valid
                  & ex_dump & ~halt_out;

  assign mem_addr  = ex_alu;
  assign mem_wdata = ex_b;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    issue     = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    pass      = 1'b0;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (op) begin
          issue   = ~mem_busy;
          capture = issue & mem_done;
          stall   = ~capture;
          if (mem_busy) begin
            stateNext = REQ;
          end else if (!mem_done) begin
            stateNext = WAIT;
            cntNext   = '0;
          end
        end else begin
          pass = 1'b1;
        end
      end
      REQ: begin
        issue   = ~mem_busy;
        capture = issue & mem_done;
        stall   = ~capture;
        if (issue) begin
          stateNext = mem_done ? IDLE : WAIT;
          cntNext   = '0;
        end
      end
      WAIT: begin
        capture = mem_done;
        timeout = ~mem_done & (cnt == CNT_LAST);
        stall   = ~mem_done & ~timeout;
        if (capture | timeout) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // reset gates the combinational strobes immediately
  assign mem_rd    = rst & issue & ~ex_mem_wr;
  assign mem_wr    = rst & issue & ex_mem_wr;
  assign mem_dump  = rst & dumpFire;
  assign stall_out = rst & stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wb_regwrite <= 1'b0;
      wb_wreg     <= '0;
      wb_data     <= '0;
      halt_out    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (dumpFire) halt_out <= 1'b1;
      if (timeout)  err      <= 1'b1;
      unique case (1'b1)
        capture: begin
          wb_data <= (ex_mem2reg & ~ex_mem_wr)
                   ? mem_rdata : ex_alu;
          wb_regwrite <= ex_regwrite & ~ex_mem_wr;
          wb_wreg     <= ex_wreg;
        end
        pass: begin
          wb_data     <= ex_alu;
          wb_regwrite <= ex_valid & ex_regwrite;
          wb_wreg     <= ex_wreg;
        end
        default: wb_regwrite <= 1'b0;
      endcase
    end
  end

endmodule
